// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types for the decode-side hazard/forwarding controller:
// scoreboard entry layout, the empty-slot constant and forward-select encoding.
package hazard_fwd_unit_pkg;

  localparam int DEF_REG_AW = 3;
  localparam int FWD_RF     = 0;

  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic [DEF_REG_AW-1:0] rd;
    logic                  isLoad;
  } sbEntry_t;

  localparam sbEntry_t BUBBLE = '{valid: 1'b0, wr: 1'b0, rd: '0, isLoad: 1'b0};

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Decode-side bundle between the decode stage (master) and the hazard unit (slave).
interface hazard_fwd_unit_if #(
  parameter int REG_AW  = hazard_fwd_unit_pkg::DEF_REG_AW,
  parameter int NSTAGES = 3,
  parameter int CNT_W   = 16
);
  localparam int SEL_W = $clog2(NSTAGES + 1);

  logic              dec_valid;
  logic [REG_AW-1:0] dec_rs;
  logic [REG_AW-1:0] dec_rt;
  logic              dec_uses_rs;
  logic              dec_uses_rt;
  logic              dec_wr_en;
  logic [REG_AW-1:0] dec_rd;
  logic              dec_is_load;
  logic              dec_is_div;
  logic              flush;
  logic              stall;
  logic              div_busy;
  logic [SEL_W-1:0]  fwd_rs_sel;
  logic [SEL_W-1:0]  fwd_rt_sel;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output dec_valid, dec_rs, dec_rt, dec_uses_rs, dec_uses_rt,
           dec_wr_en, dec_rd, dec_is_load, dec_is_div, flush,
    input  stall, div_busy, fwd_rs_sel, fwd_rt_sel, stall_cycles
  );

  modport slave (
    input  dec_valid, dec_rs, dec_rt, dec_uses_rs, dec_uses_rt,
           dec_wr_en, dec_rd, dec_is_load, dec_is_div, flush,
    output stall, div_busy, fwd_rs_sel, fwd_rt_sel, stall_cycles
  );
endinterface

// File: rtl/hazard_fwd_unit_match.sv
// Priority encoder over the scoreboard for one source register: youngest
// matching producer selects the forward path, early-stage loads flag a hazard.
module hazard_match
  import hazard_fwd_unit_pkg::*;
#(
  parameter int NSTAGES    = 3,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = 2
) (
  input  sbEntry_t [NSTAGES:1]   sb,
  input  logic [DEF_REG_AW-1:0]  src,
  input  logic                   srcUsed,
  input  logic                   decValid,
  output logic [SEL_W-1:0]       sel,
  output logic                   loadHit
);

  always_comb begin
    // NOTE: defaults assigned first so neither output can infer a latch.
    sel     = SEL_W'(FWD_RF);
    loadHit = 1'b0;
    // Walk oldest to youngest so the last hit (smallest k) wins.
    for (int k = NSTAGES; k >= 1; k--) begin
      if (sb[k].valid && sb[k].wr && (sb[k].rd == src) && srcUsed) begin
        if (decValid) sel = SEL_W'(k);
        if ((k < LOAD_READY) && sb[k].isLoad) loadHit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller beside decode: tracks in-flight destinations,
// drives stall / forward selects, freezes for divides and counts stall cycles.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int REG_AW      = DEF_REG_AW,  // rd field width is fixed by the package entry
  parameter int NSTAGES     = 3,
  parameter int LOAD_READY  = 2,
  parameter int DIV_LATENCY = 16,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_fwd_unit_if.slave  bus
);

  localparam int   SEL_W      = $clog2(NSTAGES + 1);
  localparam int   DIV_W      = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic DIV_FREEZE = (DIV_LATENCY > 1);

  sbEntry_t [NSTAGES:1] sb;
  sbEntry_t             decEntry;
  logic [DIV_W-1:0]     divCnt;
  logic [CNT_W-1:0]     stallCount;
  logic                 pendingFlush;
  logic                 kill, loadStall, divBusy, rsLoadHit, rtLoadHit, startDiv;

  hazard_match #(.NSTAGES(NSTAGES), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)) uRsMatch (
    .sb(sb), .src(bus.dec_rs), .srcUsed(bus.dec_uses_rs), .decValid(bus.dec_valid),
    .sel(bus.fwd_rs_sel), .loadHit(rsLoadHit)
  );

  hazard_match #(.NSTAGES(NSTAGES), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)) uRtMatch (
    .sb(sb), .src(bus.dec_rt), .srcUsed(bus.dec_uses_rt), .decValid(bus.dec_valid),
    .sel(bus.fwd_rt_sel), .loadHit(rtLoadHit)
  );

  // A killed decode slot never stalls: flush beats load-use.
  assign kill      = bus.flush | pendingFlush;
  assign loadStall = (rsLoadHit | rtLoadHit) & bus.dec_valid & ~kill;
  assign divBusy   = (divCnt != '0);
  assign decEntry  = '{valid: bus.dec_valid & ~kill, wr: bus.dec_wr_en,
                       rd: bus.dec_rd, isLoad: bus.dec_is_load};
  assign startDiv  = DIV_FREEZE & ~divBusy & ~loadStall & decEntry.valid & bus.dec_is_div;

  assign bus.stall        = divBusy | loadStall;
  assign bus.div_busy     = divBusy;
  assign bus.stall_cycles = stallCount;

  // NOTE: every register here, scoreboard included, is cleared by the async reset
  // and updated with non-blocking assignments so the shift reads pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb           <= '0;
      divCnt       <= '0;
      pendingFlush <= 1'b0;
      stallCount   <= '0;
    end else begin
      if (bus.stall && (stallCount != '1)) stallCount <= stallCount + 1'b1;

      if (divBusy) begin
        divCnt <= divCnt - 1'b1;
        if (bus.flush) pendingFlush <= 1'b1;
      end else begin
        sb[1] <= loadStall ? BUBBLE : decEntry;
        for (int k = 2; k <= NSTAGES; k++) sb[k] <= sb[k-1];
        pendingFlush <= 1'b0;
        if (startDiv) divCnt <= DIV_W'(DIV_LATENCY - 1);
      end
    end
  end

endmodule
